// File: rtl/bsg_axil_fifo_slave_pkg.sv
// Shared constants and types for the AXI-Lite FIFO slave bridge.
package bsg_axil_fifo_slave_pkg;

    // Register offsets, compared on addr[15:0]
    localparam logic [15:0] tx_data_addr_gp = 16'h1000;
    localparam logic [15:0] tx_vac_addr_gp  = 16'h1010;
    localparam logic [15:0] rx_occ_addr_gp  = 16'h1018;
    localparam logic [15:0] rx_data_addr_gp = 16'h101C;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/bsg_axil_fifo_slave_fifo.sv
// 1r1w register FIFO, first-word-fall-through head, with occupancy count.
module bsg_axil_fifo_slave_fifo #(
    parameter int els_p   = 16,
    parameter int width_p = 32,
    localparam int cnt_width_lp = $clog2(els_p + 1),
    localparam int ptr_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      data_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [cnt_width_lp-1:0] count_o
);

    localparam logic [cnt_width_lp-1:0] els_cnt_lp = cnt_width_lp'(els_p);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] rptr_r, wptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    full, empty, push, pop;

    assign full  = (count_r == els_cnt_lp);
    assign empty = (count_r == '0);
    assign pop   = yumi_i & ~empty;
    // A full FIFO may still take a word when the head leaves in the same cycle
    assign push  = v_i & (~full | pop);

    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = mem_r[rptr_r];
    assign count_o = count_r;

    // Pointer and occupancy tracking; pointers wrap at the power-of-2 depth
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) wptr_r <= wptr_r + 1'b1;
            if (pop)  rptr_r <= rptr_r + 1'b1;
            if (push & ~pop)      count_r <= count_r + 1'b1;
            else if (pop & ~push) count_r <= count_r - 1'b1;
        end
    end

    // Storage write; contents need no reset since the count gates visibility
    always_ff @(posedge clk_i) begin
        if (push) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_axil_fifo_slave_bridge.sv
// AXI4-Lite slave bridging host writes/reads to TX and RX word FIFOs.
module bsg_axil_fifo_slave_bridge
    import bsg_axil_fifo_slave_pkg::*;
#(
    parameter int fifo_els_p        = 16,
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32,
    localparam int cnt_width_lp     = $clog2(fifo_els_p + 1)
) (
    input  logic                           pcie_clk_i,
    input  logic                           pcie_reset_i,

    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,

    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,

    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,

    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,

    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,

    output logic [axil_data_width_p-1:0]   tx_data_o,
    output logic                           tx_v_o,
    input  logic                           tx_ready_i,

    input  logic [axil_data_width_p-1:0]   rx_data_i,
    input  logic                           rx_v_i,
    output logic                           rx_ready_o
);

    wr_state_e wr_state_r;
    rd_state_e rd_state_r;
    axil_resp_e bresp_r, rresp_r, rd_resp_n;

    logic                         bvalid_r, rvalid_r, arready_r;
    logic [axil_data_width_p-1:0] rdata_r, rd_data_n;
    logic [cnt_width_lp-1:0]      tx_count, rx_count, tx_vacancy;
    logic [axil_data_width_p-1:0] rx_head;
    logic                         tx_not_full, rx_not_empty;
    logic                         wr_is_tx, wr_accept, tx_push;
    logic                         rd_accept, rx_pop;
    logic [15:0]                  rd_addr;
    logic                         unused_bits;

    // Only the low 16 address bits decode; byte strobes are not honoured
    assign unused_bits = ^{s_axil_awaddr_i[axil_addr_width_p-1:16],
                           s_axil_araddr_i[axil_addr_width_p-1:16], s_axil_wstrb_i};

    bsg_axil_fifo_slave_fifo #(.els_p(fifo_els_p), .width_p(axil_data_width_p)) tx_fifo (
        .clk_i(pcie_clk_i), .reset_i(pcie_reset_i),
        .data_i(s_axil_wdata_i), .v_i(tx_push), .ready_o(tx_not_full),
        .data_o(tx_data_o), .v_o(tx_v_o), .yumi_i(tx_ready_i & tx_v_o),
        .count_o(tx_count)
    );

    bsg_axil_fifo_slave_fifo #(.els_p(fifo_els_p), .width_p(axil_data_width_p)) rx_fifo (
        .clk_i(pcie_clk_i), .reset_i(pcie_reset_i),
        .data_i(rx_data_i), .v_i(rx_v_i & rx_ready_o), .ready_o(rx_ready_o),
        .data_o(rx_head), .v_o(rx_not_empty), .yumi_i(rx_pop),
        .count_o(rx_count)
    );

    assign wr_is_tx  = (s_axil_awaddr_i[15:0] == tx_data_addr_gp);
    assign wr_accept = (wr_state_r == W_IDLE) & s_axil_awvalid_i & s_axil_wvalid_i
                     & (tx_not_full | ~wr_is_tx);
    assign tx_push   = wr_accept & wr_is_tx;

    assign s_axil_awready_o = wr_accept;
    assign s_axil_wready_o  = wr_accept;
    assign s_axil_bvalid_o  = bvalid_r;
    assign s_axil_bresp_o   = bresp_r;

    // Write FSM: joint AW+W acceptance, one outstanding B response
    always_ff @(posedge pcie_clk_i or posedge pcie_reset_i) begin
        if (pcie_reset_i) begin
            wr_state_r <= W_IDLE;
            bvalid_r   <= 1'b0;
            bresp_r    <= OKAY;
        end else begin
            case (wr_state_r)
                W_IDLE: if (wr_accept) begin
                    wr_state_r <= W_RESP;
                    bvalid_r   <= 1'b1;
                    bresp_r    <= wr_is_tx ? OKAY : SLVERR;
                end
                W_RESP: if (s_axil_bready_i) begin
                    wr_state_r <= W_IDLE;
                    bvalid_r   <= 1'b0;
                end
                default: wr_state_r <= W_IDLE;
            endcase
        end
    end

    assign rd_addr    = s_axil_araddr_i[15:0];
    assign rd_accept  = arready_r & s_axil_arvalid_i;
    assign tx_vacancy = cnt_width_lp'(fifo_els_p) - tx_count;

    // Read response selection; counts are the pre-update values of this cycle
    always_comb begin
        rd_data_n = '0;
        rd_resp_n = SLVERR;
        rx_pop    = 1'b0;
        case (rd_addr)
            tx_vac_addr_gp: begin
                rd_data_n[cnt_width_lp-1:0] = tx_vacancy;
                rd_resp_n = OKAY;
            end
            rx_occ_addr_gp: begin
                rd_data_n[cnt_width_lp-1:0] = rx_count;
                rd_resp_n = OKAY;
            end
            rx_data_addr_gp: if (rx_not_empty) begin
                rd_data_n = rx_head;
                rd_resp_n = OKAY;
                rx_pop    = rd_accept;
            end
            default: ;
        endcase
    end

    assign s_axil_arready_o = arready_r;
    assign s_axil_rvalid_o  = rvalid_r;
    assign s_axil_rdata_o   = rdata_r;
    assign s_axil_rresp_o   = rresp_r;

    // Read FSM: capture response on accept, hold it until rready
    always_ff @(posedge pcie_clk_i or posedge pcie_reset_i) begin
        if (pcie_reset_i) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= '0;
            rresp_r    <= OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: if (rd_accept) begin
                    rd_state_r <= R_DATA;
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b1;
                    rdata_r    <= rd_data_n;
                    rresp_r    <= rd_resp_n;
                end else begin
                    arready_r  <= 1'b1;
                end
                R_DATA: if (s_axil_rready_i) begin
                    rd_state_r <= R_IDLE;
                    arready_r  <= 1'b1;
                    rvalid_r   <= 1'b0;
                end
                default: rd_state_r <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_axil_fifo_slave_bridge.sv
// Self-checking bench for bsg_axil_fifo_slave_bridge.
module tb_bsg_axil_fifo_slave_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rx_data = '0;
    logic [3:0]  wstrb = '1;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1, tx_ready = 1'b0, rx_v = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, tx_v, rx_ready;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, tx_data;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic [1:0] wq[$];
    rexp_t      rq[$];
    vec_t       vecs[11];

    always #5 clk = ~clk;

    bsg_axil_fifo_slave_bridge #(
        .fifo_els_p(16), .axil_addr_width_p(32), .axil_data_width_p(32)
    ) dut (
        .pcie_clk_i(clk), .pcie_reset_i(rst),
        .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .tx_data_o(tx_data), .tx_v_o(tx_v), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_v_i(rx_v), .rx_ready_o(rx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Completes a write whose AW/W are already driven; expected bresp is queued
    task automatic finish_write();
        int n = 0;
        logic [1:0] e;
        #1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_handshake", awready, 1);
        check("w_handshake", wready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        e = wq.pop_front();
        check("bvalid", bvalid, 1);
        check("bresp", bresp, e);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] exp);
        wq.push_back(exp);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        finish_write();
    endtask

    task automatic axil_read(input logic [31:0] a, input logic [31:0] exp_d,
                             input logic [1:0] exp_r, input bit push_rx, input logic [31:0] rxd);
        int n = 0;
        rexp_t e;
        rq.push_back('{data: exp_d, resp: exp_r});
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_handshake", arready, 1);
        if (push_rx) begin rx_v = 1'b1; rx_data = rxd; end
        @(posedge clk); #1;
        arvalid = 1'b0; rx_v = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        e = rq.pop_front();
        check("rvalid", rvalid, 1);
        check("rdata", rdata, e.data);
        check("rresp", rresp, e.resp);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic rx_push(input logic [31:0] d);
        rx_v = 1'b1; rx_data = d;
        @(negedge clk);
        rx_v = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 2'b00};
        vecs[1]  = '{1'b0, 32'h0000_1010, 32'h0, 32'd15, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_2000, 32'h1111_1111, 32'h0, 2'b10};
        vecs[3]  = '{1'b0, 32'h0000_1004, 32'h0, 32'h0, 2'b10};
        vecs[4]  = '{1'b0, 32'h0000_1010, 32'h0, 32'd15, 2'b00};
        vecs[5]  = '{1'b0, 32'h0000_1018, 32'h0, 32'd0, 2'b00};
        vecs[6]  = '{1'b0, 32'h0000_101C, 32'h0, 32'h0, 2'b10};
        vecs[7]  = '{1'b1, 32'h0000_1010, 32'h2222_2222, 32'h0, 2'b10};
        vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0, 32'h0, 2'b10};
        vecs[9]  = '{1'b1, 32'hABCD_1000, 32'hCAFE_F00D, 32'h0, 2'b00};
        vecs[10] = '{1'b0, 32'h5555_1010, 32'h0, 32'd14, 2'b00};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_tx_v", tx_v, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rx_ready", rx_ready, 1);

        // Table: basic write/read decode, error paths, high-address aliasing
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) axil_write(vecs[i].addr, vecs[i].data, vecs[i].exp_resp);
            else axil_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, 1'b0, '0);
        end
        check("tx_v_after_push", tx_v, 1);
        check("tx_head_1", tx_data, 32'hDEAD_BEEF);
        tx_ready = 1'b1;
        @(negedge clk);
        check("tx_head_2", tx_data, 32'hCAFE_F00D);
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_drained", tx_v, 0);

        // TX full: 16 writes complete, 17th stalls until one word drains
        for (int i = 0; i < 16; i++) axil_write(32'h1000, 32'h7000_0000 + i, 2'b00);
        axil_read(32'h1010, 32'd0, 2'b00, 1'b0, '0);
        wq.push_back(2'b00);
        awaddr = 32'h1000; wdata = 32'h0000_0017; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_awready_low", awready, 0);
            check("full_wready_low", wready, 0);
        end
        check("full_head", tx_data, 32'h7000_0000);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        finish_write();
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("tx_order", tx_data, (i == 16) ? 32'h17 : 32'h7000_0000 + i);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("tx_empty_after_order", tx_v, 0);

        // RX: occupancy then in-order pops, empty pop errors
        for (int i = 1; i <= 3; i++) rx_push(32'h3AB4_0000 + i);
        axil_read(32'h1018, 32'd3, 2'b00, 1'b0, '0);
        for (int i = 1; i <= 3; i++) axil_read(32'h101C, 32'h3AB4_0000 + i, 2'b00, 1'b0, '0);
        axil_read(32'h101C, 32'h0, 2'b10, 1'b0, '0);

        // Occupancy sampled before a same-cycle push
        rx_push(32'h4400_0001);
        rx_push(32'h4400_0002);
        axil_read(32'h1018, 32'd2, 2'b00, 1'b1, 32'h4400_0003);
        axil_read(32'h1018, 32'd3, 2'b00, 1'b0, '0);
        for (int i = 1; i <= 3; i++) axil_read(32'h101C, 32'h4400_0000 + i, 2'b00, 1'b0, '0);

        // RX full boundary
        for (int i = 0; i < 16; i++) rx_push(32'h5500_0000 + i);
        check("rx_full_ready", rx_ready, 0);
        axil_read(32'h1018, 32'd16, 2'b00, 1'b0, '0);
        axil_read(32'h101C, 32'h5500_0000, 2'b00, 1'b0, '0);
        check("rx_ready_after_pop", rx_ready, 1);

        // Back-pressure hold, then asynchronous reset drops responses and FIFOs
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h1000; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h1010; arvalid = 1'b1;
        #1;
        check("hold_aw_accept", awready, 1);
        check("hold_ar_accept", arready, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid", bvalid, 1);
            check("hold_bresp", bresp, 2'b00);
            check("hold_rvalid", rvalid, 1);
            check("hold_rdata", rdata, 32'd16);
            check("hold_no_aw", awready, 0);
            check("hold_no_ar", arready, 0);
        end
        check("hold_tx_v", tx_v, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_bvalid", bvalid, 0);
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_tx_v", tx_v, 0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axil_read(32'h1018, 32'd0, 2'b00, 1'b0, '0);
        axil_read(32'h1010, 32'd16, 2'b00, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
